// File: rtl/load_store_ctrl.sv
// RV32I load/store unit front end: one access at a time, alignment and legality checks,
// byte-lane strobes and replication for stores, lane select and extension for loads.
module load_store_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iLoad,
  input  logic        iStore,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic        oStall,
  output logic        oDone,
  output logic [31:0] oRData,
  output logic [1:0]  oFault,
  output logic        oMemReq,
  input  logic        iMemGnt,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [3:0]  oMemStrb,
  input  logic        iMemRValid,
  input  logic [31:0] iMemRData
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam logic [1:0] FaultOk      = 2'b00;
  localparam logic [1:0] FaultAlign   = 2'b01;
  localparam logic [1:0] FaultTimeout = 2'b10;
  localparam logic [1:0] FaultIllegal = 2'b11;
  localparam logic [3:0] CntLast      = 4'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        store_q, store_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;

  logic is_load_req, illegal, misaligned;

  function automatic logic [31:0] load_extend(input logic [2:0] f, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [31:0] s;
    s = d >> {a, 3'b000};
    case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign is_load_req = iLoad & ~iStore;
  assign illegal     = (iLoad & iStore) |
                       (iLoad  & !(iFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) |
                       (iStore & !(iFunct3 inside {3'b000, 3'b001, 3'b010}));
  assign misaligned  = ((iFunct3[1:0] == 2'b01) & iAddr[0]) |
                       ((iFunct3[1:0] == 2'b10) & (iAddr[1:0] != 2'b00));

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    store_d  = store_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (iLoad | iStore) begin
          funct3_d = iFunct3;
          addr_d   = iAddr;
          wdata_d  = iWData;
          store_d  = iStore & ~iLoad;
          if (illegal || misaligned) begin
            fault_d = illegal ? FaultIllegal : FaultAlign;
            if (is_load_req) rdata_d = '0;
            state_d = DONE;
          end else begin
            fault_d = FaultOk;
            state_d = REQ;
          end
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (state_q == REQ && iMemGnt) begin
          state_d = store_q ? DONE : WAIT;
        end else if (state_q == WAIT && iMemRValid) begin
          rdata_d = load_extend(funct3_q, addr_q[1:0], iMemRData);
          state_d = DONE;
        end else if (cnt_q == CntLast) begin
          // Abort: progress in the final cycle still wins over the timeout.
          fault_d = FaultTimeout;
          if (!store_q) rdata_d = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!iRstN) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      fault_q  <= FaultOk;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      store_q  <= store_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Memory channel is driven only while requesting; otherwise everything reads as zero.
  always_comb begin
    oMemReq   = 1'b0;
    oMemWe    = 1'b0;
    oMemAddr  = '0;
    oMemWData = '0;
    oMemStrb  = '0;
    if (state_q == REQ) begin
      oMemReq  = 1'b1;
      oMemWe   = store_q;
      oMemAddr = {addr_q[31:2], 2'b00};
      case (funct3_q[1:0])
        2'b00: begin
          oMemStrb  = 4'b0001 << addr_q[1:0];
          oMemWData = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          oMemStrb  = 4'b0011 << addr_q[1:0];
          oMemWData = {2{wdata_q[15:0]}};
        end
        default: begin
          oMemStrb  = 4'b1111;
          oMemWData = wdata_q;
        end
      endcase
      if (!store_q) oMemWData = '0;
    end
  end

  assign oStall = ((state_q == IDLE) & (iLoad | iStore)) | (state_q == REQ) | (state_q == WAIT);
  assign oDone  = (state_q == DONE);
  assign oFault = fault_q;
  assign oRData = rdata_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: directed scenarios plus randomized back-to-back accesses;
// completions are checked against a queue of expected {rdata, fault}.
module tb_load_store_ctrl;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iLoad = 1'b0, iStore = 1'b0;
  logic [2:0]  iFunct3 = '0;
  logic [31:0] iAddr = '0, iWData = '0;
  logic        oStall, oDone;
  logic [31:0] oRData;
  logic [1:0]  oFault;
  logic        oMemReq, oMemWe;
  logic        iMemGnt = 1'b0;
  logic [31:0] oMemAddr, oMemWData;
  logic [3:0]  oMemStrb;
  logic        iMemRValid = 1'b0;
  logic [31:0] iMemRData = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] exp_rdata = '0;

  load_store_ctrl #(.TIMEOUT(15)) dut (
    .iClk(iClk), .iRstN(iRstN), .iLoad(iLoad), .iStore(iStore), .iFunct3(iFunct3),
    .iAddr(iAddr), .iWData(iWData), .oStall(oStall), .oDone(oDone), .oRData(oRData),
    .oFault(oFault), .oMemReq(oMemReq), .iMemGnt(iMemGnt), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemStrb(oMemStrb),
    .iMemRValid(iMemRValid), .iMemRData(iMemRData)
  );

  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Completion monitor: every oDone pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      #2;
      if (iRstN && oDone) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL done_unexpected: got oDone=1 with no access outstanding, required none");
        end else begin
          e = sb.pop_front();
          if (oRData !== e.rdata || oFault !== e.fault) begin
            miscompares++;
            $display("FAIL done_result: got rdata=%h fault=%b, required rdata=%h fault=%b",
                     oRData, oFault, e.rdata, e.fault);
          end
        end
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[a*8 +: 8];
    h = d[a[1]*16 +: 16];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  task automatic test_reset();
    iRstN = 1'b0;
    repeat (2) @(negedge iClk);
    #2;
    vectors++;
    if ({oStall, oDone, oFault, oRData, oMemReq, oMemWe, oMemStrb, oMemAddr, oMemWData} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall=%b done=%b fault=%b rdata=%h req=%b we=%b strb=%b addr=%h wdata=%h, required all zero",
               oStall, oDone, oFault, oRData, oMemReq, oMemWe, oMemStrb, oMemAddr, oMemWData);
    end
    @(negedge iClk);
    iRstN = 1'b1;
  endtask

  task automatic test_lb();
    @(negedge iClk);
    iLoad = 1'b1; iFunct3 = 3'b000; iAddr = 32'h0000_1003;
    exp_rdata = 32'hFFFF_FF80;
    sb.push_back('{exp_rdata, 2'b00});
    #2; vectors++;
    if ({oStall, oMemReq} !== 2'b10) begin
      miscompares++; $display("FAIL lb_cycle0: got stall,req=%b, required 10", {oStall, oMemReq});
    end
    @(negedge iClk);
    iLoad = 1'b0; iMemGnt = 1'b1;
    #2; vectors++;
    if ({oStall, oMemReq, oMemWe, oMemAddr} !== {3'b110, 32'h0000_1000}) begin
      miscompares++;
      $display("FAIL lb_cycle1: got stall=%b req=%b we=%b addr=%h, required 1 1 0 00001000",
               oStall, oMemReq, oMemWe, oMemAddr);
    end
    @(negedge iClk);
    iMemGnt = 1'b0; iMemRValid = 1'b1; iMemRData = 32'h80FF_FF00;
    #2; vectors++;
    if ({oStall, oMemReq, oMemAddr} !== {2'b10, 32'h0}) begin
      miscompares++;
      $display("FAIL lb_cycle2: got stall=%b req=%b addr=%h, required 1 0 0", oStall, oMemReq, oMemAddr);
    end
    @(negedge iClk);
    iMemRValid = 1'b0;
    #2; vectors++;
    if ({oDone, oStall} !== 2'b10) begin
      miscompares++; $display("FAIL lb_cycle3: got done,stall=%b, required 10", {oDone, oStall});
    end
    @(negedge iClk);
    #2; vectors++;
    if (oDone !== 1'b0 || oRData !== 32'hFFFF_FF80) begin
      miscompares++;
      $display("FAIL lb_hold: got done=%b rdata=%h, required 0 ffffff80", oDone, oRData);
    end
  endtask

  task automatic test_sh();
    @(negedge iClk);
    iStore = 1'b1; iFunct3 = 3'b001; iAddr = 32'h0000_2002; iWData = 32'h0000_BEEF;
    sb.push_back('{exp_rdata, 2'b00});
    @(negedge iClk);
    iStore = 1'b0; iMemGnt = 1'b1;
    #2; vectors++;
    if ({oMemReq, oMemWe, oMemAddr, oMemStrb, oMemWData} !== {2'b11, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF}) begin
      miscompares++;
      $display("FAIL sh_request: got req=%b we=%b addr=%h strb=%b wdata=%h, required 1 1 00002000 1100 beefbeef",
               oMemReq, oMemWe, oMemAddr, oMemStrb, oMemWData);
    end
    @(negedge iClk);
    iMemGnt = 1'b0;
    #2; vectors++;
    if ({oDone, oMemReq} !== 2'b10) begin
      miscompares++; $display("FAIL sh_done: got done,req=%b, required 10", {oDone, oMemReq});
    end
  endtask

  task automatic test_misaligned();
    @(negedge iClk);
    iLoad = 1'b1; iFunct3 = 3'b010; iAddr = 32'h0000_3001;
    exp_rdata = '0;
    sb.push_back('{exp_rdata, 2'b01});
    #2; vectors++;
    if ({oStall, oMemReq} !== 2'b10) begin
      miscompares++; $display("FAIL misalign_issue: got stall,req=%b, required 10", {oStall, oMemReq});
    end
    @(negedge iClk);
    iLoad = 1'b0;
    #2; vectors++;
    if ({oDone, oMemReq, oFault} !== 4'b1001) begin
      miscompares++;
      $display("FAIL misalign_done: got done=%b req=%b fault=%b, required 1 0 01", oDone, oMemReq, oFault);
    end
  endtask

  task automatic test_lhu();
    @(negedge iClk);
    iLoad = 1'b1; iFunct3 = 3'b101; iAddr = 32'h0000_3002;
    exp_rdata = 32'h0000_8001;
    sb.push_back('{exp_rdata, 2'b00});
    @(negedge iClk);
    iLoad = 1'b0; iMemGnt = 1'b1;
    @(negedge iClk);
    iMemGnt = 1'b0; iMemRValid = 1'b1; iMemRData = 32'h8001_0000;
    @(negedge iClk);
    iMemRValid = 1'b0;
    #2; vectors++;
    if (oDone !== 1'b1 || oRData !== 32'h0000_8001) begin
      miscompares++;
      $display("FAIL lhu_done: got done=%b rdata=%h, required 1 00008001", oDone, oRData);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge iClk);
    iLoad = 1'b1; iFunct3 = 3'b010; iAddr = 32'h0000_0050;
    @(negedge iClk);
    iLoad = 1'b0; iMemGnt = 1'b1;
    @(negedge iClk);
    iMemGnt = 1'b0; iRstN = 1'b0;
    @(negedge iClk);
    iRstN = 1'b1; iMemRValid = 1'b1; iMemRData = 32'hDEAD_BEEF;
    exp_rdata = '0;
    #2; vectors++;
    if ({oStall, oDone, oMemReq, oRData} !== '0) begin
      miscompares++;
      $display("FAIL resetmid_after: got stall=%b done=%b req=%b rdata=%h, required 0 0 0 0",
               oStall, oDone, oMemReq, oRData);
    end
    @(negedge iClk);
    iMemRValid = 1'b0;
    #2; vectors++;
    if ({oDone, oRData} !== '0) begin
      miscompares++;
      $display("FAIL resetmid_late_rvalid: got done=%b rdata=%h, required 0 0", oDone, oRData);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f;
    logic [31:0] a, wd, rd;
    logic        st;
    logic [3:0]  strb;
    logic [31:0] mwd;
    int          gd, rvd;
    for (int n = 0; n < 12; n++) begin
      st = ($urandom_range(0, 1) == 1);
      if (st) f = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f = 3'b000; 1: f = 3'b001; 2: f = 3'b010; 3: f = 3'b100; default: f = 3'b101;
        endcase
      end
      a = $urandom; wd = $urandom; rd = $urandom;
      if (f[1:0] == 2'b01) a[0] = 1'b0;
      if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      gd = $urandom_range(0, 2); rvd = $urandom_range(0, 2);
      case (f[1:0])
        2'b00:   begin strb = 4'b0001 << a[1:0]; mwd = {4{wd[7:0]}}; end
        2'b01:   begin strb = (a[1] ? 4'b1100 : 4'b0011); mwd = {2{wd[15:0]}}; end
        default: begin strb = 4'b1111; mwd = wd; end
      endcase
      if (!st) exp_rdata = model_load(f, a[1:0], rd);
      sb.push_back('{exp_rdata, 2'b00});

      @(negedge iClk);
      iLoad = !st; iStore = st; iFunct3 = f; iAddr = a; iWData = wd;
      #2; vectors++;
      if (oStall !== 1'b1) begin
        miscompares++; $display("FAIL b2b_stall[%0d]: got %b, required 1", n, oStall);
      end
      @(negedge iClk);
      iLoad = 1'b0; iStore = 1'b0;
      repeat (gd) @(negedge iClk);
      iMemGnt = 1'b1;
      #2; vectors++;
      if ({oMemReq, oMemWe, oMemAddr} !== {1'b1, st, a[31:2], 2'b00} ||
          (st && {oMemStrb, oMemWData} !== {strb, mwd})) begin
        miscompares++;
        $display("FAIL b2b_request[%0d]: got we=%b addr=%h strb=%b wdata=%h, required we=%b addr=%h strb=%b wdata=%h",
                 n, oMemWe, oMemAddr, oMemStrb, oMemWData, st, {a[31:2], 2'b00}, strb, mwd);
      end
      @(negedge iClk);
      iMemGnt = 1'b0;
      if (!st) begin
        repeat (rvd) @(negedge iClk);
        iMemRValid = 1'b1; iMemRData = rd;
        @(negedge iClk);
        iMemRValid = 1'b0;
      end
      #2; vectors++;
      if (oDone !== 1'b1) begin
        miscompares++; $display("FAIL b2b_done[%0d]: got %b, required 1", n, oDone);
      end
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    @(negedge iClk);
    iLoad = 1'b1; iFunct3 = 3'b010; iAddr = 32'h0000_4000;
    exp_rdata = '0;
    sb.push_back('{exp_rdata, 2'b10});
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk);
      iLoad = 1'b0;
      #2;
      if (oDone) break;
      if (oMemReq) req_cycles++;
    end
    vectors++;
    if (req_cycles != 15 || {oDone, oMemReq, oFault} !== 4'b1010) begin
      miscompares++;
      $display("FAIL timeout: got req_cycles=%0d done=%b req=%b fault=%b, required 15 1 0 10",
               req_cycles, oDone, oMemReq, oFault);
    end
  endtask

  task automatic test_illegal();
    logic seen_req = 1'b0;
    @(negedge iClk);
    iLoad = 1'b1; iStore = 1'b1; iFunct3 = 3'b010; iAddr = 32'h0;
    sb.push_back('{exp_rdata, 2'b11});
    #2; seen_req = oMemReq;
    @(negedge iClk);
    iLoad = 1'b0; iStore = 1'b0;
    #2; vectors++;
    if (seen_req || {oDone, oMemReq, oFault} !== 4'b1011) begin
      miscompares++;
      $display("FAIL illegal_both: got done=%b req=%b fault=%b, required 1 0 11", oDone, oMemReq, oFault);
    end
    @(negedge iClk);
    iLoad = 1'b1; iFunct3 = 3'b011; iAddr = 32'h0000_0020;
    sb.push_back('{exp_rdata, 2'b11});
    @(negedge iClk);
    iLoad = 1'b0;
    #2; vectors++;
    if ({oDone, oMemReq, oFault} !== 4'b1011) begin
      miscompares++;
      $display("FAIL illegal_funct3: got done=%b req=%b fault=%b, required 1 0 11", oDone, oMemReq, oFault);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_lhu();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    test_illegal();
    repeat (3) @(negedge iClk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL outstanding: got %0d expected completions still queued, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
